// File: rtl/mem_read_arbiter_pkg.sv
// Shared constants and types for the packet-memory read arbiter and its round-robin picker.
// Defaults mirror the switch-wide port count and the packet SRAM geometry.
package mem_read_arbiter_pkg;

    localparam int SW_NUM_PORTS    = 4;
    localparam int MEM_ADDR_W      = 10;
    localparam int MEM_BLOCK_BYTES = 64;
    localparam int RXTX_DATA_WIDTH = 8;
    localparam int MEM_RD_LAT      = 1;

    localparam int SW_PID_W = (SW_NUM_PORTS > 1) ? $clog2(SW_NUM_PORTS) : 1;

    typedef logic [SW_PID_W-1:0] port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t id;
    } rd_tag_t;

    // Index width for an N-entry port space; a single port still needs one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
// Kept free of state so the write-side arbiter can reuse it with its own pointer.
module rr_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    // Scan from the farthest offset back to ptr so the nearest requester is written last.
    always_comb begin
        logic [IW-1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % N);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares the packet SRAM read port among per-port read controllers: one held read per port,
// one round-robin grant per cycle, and a port-id tag pipeline that routes returning data.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int NUM_PORTS   = SW_NUM_PORTS,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int BLOCK_BYTES = MEM_BLOCK_BYTES,
    parameter int DATA_WIDTH  = RXTX_DATA_WIDTH,
    parameter int MEM_LAT     = MEM_RD_LAT
) (
    input  logic                              switch_clk,
    input  logic                              switch_rst,
    input  logic [NUM_PORTS-1:0]              req_re_i,
    input  logic [ADDR_W-1:0]                 req_addr_i [NUM_PORTS],
    output logic                              mem_re_o,
    output logic [ADDR_W-1:0]                 mem_raddr_o,
    input  logic [BLOCK_BYTES*DATA_WIDTH-1:0] mem_rdata_i,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    output logic [BLOCK_BYTES*DATA_WIDTH-1:0] rdata_o [NUM_PORTS],
    output logic [NUM_PORTS-1:0]              proto_err_o
);

    localparam int PID_W = id_w(NUM_PORTS);

    typedef struct packed {
        logic             valid;
        logic [PID_W-1:0] id;
    } tag_t;

    logic [NUM_PORTS-1:0] pend_q, pend_d;
    logic [NUM_PORTS-1:0] busy_q, busy_d;
    logic [NUM_PORTS-1:0] err_q, err_d;
    logic [ADDR_W-1:0]    paddr_q [NUM_PORTS];
    logic [ADDR_W-1:0]    paddr_d [NUM_PORTS];
    logic [PID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]    mem_raddr_q, mem_raddr_d;
    tag_t                 issue_tag_q, issue_tag_d;
    tag_t                 ret_tag_q [MEM_LAT];
    tag_t                 ret_tag_d [MEM_LAT];
    tag_t                 tail_tag;

    logic                 grant_valid;
    logic [PID_W-1:0]     grant_idx;

    rr_arbiter #(
        .N  (NUM_PORTS),
        .IW (PID_W)
    ) u_rr (
        .req         (pend_q),
        .ptr         (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign tail_tag    = ret_tag_q[MEM_LAT-1];
    assign mem_re_o    = mem_re_q;
    assign mem_raddr_o = mem_raddr_q;
    assign proto_err_o = err_q;

    // The tail tag lines up with the cycle the SRAM data is valid, so it alone picks the owner.
    always_comb begin
        rvalid_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rdata_o[p] = mem_rdata_i;
            if (tail_tag.valid && (tail_tag.id == PID_W'(p))) begin
                rvalid_o[p] = 1'b1;
            end
        end
    end

    always_comb begin
        pend_d      = pend_q;
        busy_d      = busy_q;
        err_d       = err_q;
        paddr_d     = paddr_q;
        rr_ptr_d    = rr_ptr_q;
        mem_re_d    = grant_valid;
        mem_raddr_d = mem_raddr_q;
        issue_tag_d = '{valid: grant_valid, id: grant_idx};

        ret_tag_d[0] = issue_tag_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            ret_tag_d[i] = ret_tag_q[i-1];
        end

        if (grant_valid) begin
            pend_d[grant_idx] = 1'b0;
            mem_raddr_d       = paddr_q[grant_idx];
            rr_ptr_d          = (grant_idx == PID_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PID_W'(1);
        end

        // A port whose data returns this cycle may already queue its next read.
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (req_re_i[p] && (!busy_q[p] || rvalid_o[p])) begin
                pend_d[p]  = 1'b1;
                busy_d[p]  = 1'b1;
                paddr_d[p] = req_addr_i[p];
            end else begin
                if (req_re_i[p]) begin
                    err_d[p] = 1'b1;
                end
                if (rvalid_o[p]) begin
                    busy_d[p] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge switch_clk) begin
        if (switch_rst) begin
            pend_q      <= '0;
            busy_q      <= '0;
            err_q       <= '0;
            paddr_q     <= '{default: '0};
            rr_ptr_q    <= '0;
            mem_re_q    <= 1'b0;
            mem_raddr_q <= '0;
            issue_tag_q <= '0;
            ret_tag_q   <= '{default: '0};
        end else begin
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            paddr_q     <= paddr_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_re_q    <= mem_re_d;
            mem_raddr_q <= mem_raddr_d;
            issue_tag_q <= issue_tag_d;
            ret_tag_q   <= ret_tag_d;
        end
    end

endmodule
